// File: rtl/flash_ctrl.sv
// flash_ctrl: parallel NOR flash bus sequencer with JEDEC program/erase,
// DQ6 toggle polling with timeout and address auto-increment.
module flash_ctrl #(
    parameter int ADDR_W = 19,
    parameter int ACC_CYC = 3,
    parameter logic [ADDR_W-1:0] UNLOCK1 = 'h555,
    parameter logic [ADDR_W-1:0] UNLOCK2 = 'h2AA,
    parameter int POLL_MAX = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              addr_load,
    input  logic              autoinc_ena,
    input  logic [1:0]        cmd,
    input  logic              cmd_valid,
    input  logic [7:0]        wr_buffer,
    output logic [7:0]        rd_buffer,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] rom_a,
    output logic [7:0]        rom_d_out,
    output logic              rom_d_oe,
    input  logic [7:0]        rom_d_in,
    output logic              rom_cs_n,
    output logic              rom_oe_n,
    output logic              rom_we_n
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, NEXT, POLL_CHK, FINISH} state_t;
    localparam logic [1:0] C_READ = 2'd0, C_PROG = 2'd2, C_ERASE = 2'd3;

    state_t            state_q;
    logic [1:0]        cmd_q;
    logic [2:0]        step_q;
    logic [3:0]        cnt_q;
    logic [19:0]       poll_cnt_q;
    logic              poll_q, rd_q, prev_dq6_q;
    logic [7:0]        rd_buffer_q, rom_d_out_q;
    logic [ADDR_W-1:0] cur_addr_q, rom_a_q;
    logic              busy_q, done_q, error_q, d_oe_q, cs_n_q, oe_n_q, we_n_q;

    logic              idle, pr, complete, poll_end, start, cyc_rd, u1, u2, inc;
    logic [1:0]        c;
    logic [2:0]        s, last_s;
    logic [ADDR_W-1:0] base, cyc_addr;
    logic [7:0]        cyc_data;

    // Next bus cycle to launch, whether from idle, after a command write or after a poll read
    always_comb begin
        idle = state_q == IDLE || state_q == FINISH;
        c = idle ? cmd : cmd_q;
        s = idle ? 3'd0 : step_q + 3'd1;
        base = (idle && addr_load) ? addr_in : cur_addr_q;
        last_s = (cmd_q == C_ERASE) ? 3'd5 : (cmd_q == C_PROG) ? 3'd3 : 3'd0;
        pr = state_q == POLL_CHK || (state_q == NEXT && step_q == last_s && cmd_q[1]);
        complete = poll_cnt_q >= 20'd2 && prev_dq6_q == rd_buffer_q[6];
        poll_end = complete || poll_cnt_q == 20'(POLL_MAX);
        start = (idle && cmd_valid) || (state_q == NEXT && (step_q != last_s || cmd_q[1]))
              || (state_q == POLL_CHK && !poll_end);
        u1 = c[1] && (s == 3'd0 || s == 3'd2 || (c == C_ERASE && s == 3'd3));
        u2 = c[1] && (s == 3'd1 || (c == C_ERASE && s == 3'd4));
        cyc_rd = pr || c == C_READ;
        cyc_addr = pr ? cur_addr_q : u1 ? UNLOCK1 : u2 ? UNLOCK2 : base;
        cyc_data = cyc_rd ? 8'h00
                 : c == C_ERASE ? (s == 3'd2 ? 8'h80 : s == 3'd5 ? 8'h30
                                 : (s == 3'd1 || s == 3'd4) ? 8'h55 : 8'hAA)
                 : c == C_PROG ? (s == 3'd0 ? 8'hAA : s == 3'd1 ? 8'h55
                                : s == 3'd2 ? 8'hA0 : wr_buffer)
                 : wr_buffer;
        inc = autoinc_ena && cmd_q != C_ERASE && !(poll_q && !complete);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= C_READ;
            step_q      <= '0;
            cnt_q       <= '0;
            poll_cnt_q  <= '0;
            poll_q      <= 1'b0;
            rd_q        <= 1'b0;
            prev_dq6_q  <= 1'b0;
            rd_buffer_q <= '0;
            rom_d_out_q <= '0;
            cur_addr_q  <= '0;
            rom_a_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            d_oe_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FINISH: begin
                    state_q <= IDLE;
                    if (addr_load) cur_addr_q <= addr_in;
                end
                SETUP: begin
                    state_q <= STROBE;
                    cnt_q   <= '0;
                    oe_n_q  <= !rd_q;
                    we_n_q  <= rd_q;
                end
                STROBE: begin
                    if (cnt_q == 4'(ACC_CYC - 1)) begin
                        state_q <= HOLD;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        if (rd_q) begin
                            rd_buffer_q <= rom_d_in;
                            prev_dq6_q  <= rd_buffer_q[6];
                            if (poll_q) poll_cnt_q <= poll_cnt_q + 20'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    state_q <= poll_q ? POLL_CHK : NEXT;
                    cs_n_q  <= 1'b1;
                    d_oe_q  <= 1'b0;
                end
                NEXT, POLL_CHK: begin
                    if (!start) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        error_q <= poll_q && !complete;
                        if (inc) cur_addr_q <= cur_addr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (start) begin
                state_q     <= SETUP;
                cmd_q       <= c;
                step_q      <= s;
                poll_q      <= pr;
                rd_q        <= cyc_rd;
                busy_q      <= 1'b1;
                cs_n_q      <= 1'b0;
                rom_a_q     <= cyc_addr;
                rom_d_out_q <= cyc_data;
                d_oe_q      <= !cyc_rd;
            end
            if (start && idle) begin
                error_q    <= 1'b0;
                poll_cnt_q <= '0;
            end
        end
    end

    assign rd_buffer = rd_buffer_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cur_addr  = cur_addr_q;
    assign rom_a     = rom_a_q;
    assign rom_d_out = rom_d_out_q;
    assign rom_d_oe  = d_oe_q;
    assign rom_cs_n  = cs_n_q;
    assign rom_oe_n  = oe_n_q;
    assign rom_we_n  = we_n_q;
endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: scoreboarded bus-cycle checks plus direct status checks for flash_ctrl.
module tb_flash_ctrl;
    logic        clk, rst;
    logic [18:0] addr_in, cur_addr, rom_a;
    logic        addr_load, autoinc_ena, cmd_valid;
    logic [1:0]  cmd;
    logic [7:0]  wr_buffer, rd_buffer, rom_d_out, rom_d_in, rd_val;
    logic        busy, done, error, rom_d_oe, rom_cs_n, rom_oe_n, rom_we_n;
    logic        poll_mode, dq6;
    int          tog_left, n_cmp, n_bad, lat;
    logic [27:0] q[$];

    logic        in_cyc, c_rd;
    logic [18:0] c_addr;
    logic [7:0]  c_data;
    int          slen;
    logic [27:0] e;

    flash_ctrl #(.POLL_MAX(8)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_load(addr_load),
        .autoinc_ena(autoinc_ena), .cmd(cmd), .cmd_valid(cmd_valid),
        .wr_buffer(wr_buffer), .rd_buffer(rd_buffer), .busy(busy), .done(done),
        .error(error), .cur_addr(cur_addr), .rom_a(rom_a), .rom_d_out(rom_d_out),
        .rom_d_oe(rom_d_oe), .rom_d_in(rom_d_in), .rom_cs_n(rom_cs_n),
        .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n)
    );

    assign rom_d_in = poll_mode ? {1'b1, dq6, 6'b0} : rd_val;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic rd, input logic [18:0] a, input logic [7:0] d);
        q.push_back({rd, a, d});
    endtask

    task automatic issue(input logic [1:0] c, input logic ld, input logic [18:0] a);
        @(negedge clk);
        cmd = c; addr_load = ld; addr_in = a; cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0; addr_load = 0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (1) begin
            @(posedge clk); #1;
            l++;
            if (done) break;
            if (l > 3000) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
    endtask

    // Bus monitor: one scoreboard entry per completed cs_n-low bus cycle
    always @(negedge clk) begin
        if (rst) in_cyc = 0;
        else if (!rom_cs_n) begin
            if (!in_cyc) begin
                in_cyc = 1;
                slen = 0;
            end
            if (rom_d_oe && !rom_oe_n) chk("oe_overlap", 1, 0);
            if (!rom_oe_n || !rom_we_n) begin
                slen++;
                c_rd = !rom_oe_n;
                c_addr = rom_a;
                c_data = !rom_oe_n ? 8'h00 : rom_d_oe ? rom_d_out : 8'hEE;
            end
        end else if (in_cyc) begin
            in_cyc = 0;
            chk("strobe_len", slen, 3);
            if (q.size() == 0) chk("extra_cycle", 1, 0);
            else begin
                e = q.pop_front();
                chk("cycle", {c_rd, c_addr, c_data}, e);
            end
            if (c_rd && tog_left > 0) begin
                dq6 = !dq6;
                tog_left--;
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; in_cyc = 0;
        rst = 1; addr_in = 0; addr_load = 0; autoinc_ena = 0; cmd = 0; cmd_valid = 0;
        wr_buffer = 0; rd_val = 0; poll_mode = 0; dq6 = 0; tog_left = 0;
        repeat (2) @(negedge clk);
        chk("rst_status", {busy, done, error, rd_buffer}, 0);
        chk("rst_addr", {cur_addr, rom_a}, 0);
        chk("rst_bus", {rom_d_out, rom_d_oe, rom_cs_n, rom_oe_n, rom_we_n}, 4'b0111);
        rst = 0;

        rd_val = 8'h5A;
        push(1, 19'h12345, 0);
        issue(0, 1, 19'h12345);
        chk("busy_after_accept", busy, 1);
        wait_done(lat);
        chk("read_latency", lat, 6);
        chk("busy_at_done", busy, 0);
        chk("read_data", rd_buffer, 8'h5A);
        chk("read_noinc", cur_addr, 19'h12345);
        chk("read_q_empty", q.size(), 0);

        autoinc_ena = 1; wr_buffer = 8'hC3;
        push(0, 19'h7FFFF, 8'hC3);
        issue(1, 1, 19'h7FFFF);
        wait_done(lat);
        repeat (2) @(negedge clk);
        chk("write_wrap", cur_addr, 0);
        chk("write_q_empty", q.size(), 0);

        wr_buffer = 8'h77; poll_mode = 1; dq6 = 0; tog_left = 4;
        push(0, 19'h555, 8'hAA); push(0, 19'h2AA, 8'h55); push(0, 19'h555, 8'hA0);
        push(0, 19'h100, 8'h77);
        for (int i = 0; i < 6; i++) push(1, 19'h100, 0);
        issue(2, 1, 19'h100);
        repeat (8) @(negedge clk);
        cmd = 0; addr_load = 1; addr_in = 19'h3333; cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0; addr_load = 0;
        chk("prog_busy_mid", busy, 1);
        wait_done(lat);
        chk("prog_error", error, 0);
        chk("prog_rd", rd_buffer, 8'h80);
        repeat (2) @(negedge clk);
        chk("prog_inc", cur_addr, 19'h101);
        chk("prog_q_empty", q.size(), 0);

        tog_left = 1000000;
        push(0, 19'h555, 8'hAA); push(0, 19'h2AA, 8'h55); push(0, 19'h555, 8'h80);
        push(0, 19'h555, 8'hAA); push(0, 19'h2AA, 8'h55); push(0, 19'h20000, 8'h30);
        for (int i = 0; i < 8; i++) push(1, 19'h20000, 0);
        issue(3, 1, 19'h20000);
        wait_done(lat);
        chk("erase_error", error, 1);
        repeat (2) @(negedge clk);
        chk("erase_noinc", cur_addr, 19'h20000);
        chk("erase_q_empty", q.size(), 0);

        poll_mode = 0; rd_val = 8'h3C;
        push(1, 19'h20000, 0);
        issue(0, 0, 0);
        chk("error_cleared", error, 0);
        wait_done(lat);
        chk("read2_data", rd_buffer, 8'h3C);
        chk("read2_inc", cur_addr, 19'h20001);

        issue(3, 1, 19'h400);
        for (int i = 0; i < 50 && rom_we_n; i++) @(negedge clk);
        chk("we_low_before_rst", rom_we_n, 0);
        #2 rst = 1;
        #1;
        chk("rst_async", {rom_we_n, rom_cs_n, rom_oe_n, busy}, 4'b1110);
        @(negedge clk);
        #2 rst = 0;
        q.delete();
        rd_val = 8'hA5;
        push(1, 19'h55, 0);
        issue(0, 1, 19'h55);
        wait_done(lat);
        chk("post_rst_latency", lat, 6);
        chk("post_rst_data", rd_buffer, 8'hA5);
        chk("post_rst_q_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
